// File: rtl/srs_pkg.sv
// Shared types and constants for the stream rate scheduler.
// Also used by the reusable LFSR random source.
package srs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ADVANCE
    } state_t;

    localparam int RATE_MAX = 100;
    localparam int RATE_W = 7;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [RATE_W-1:0] clamp_rate(
        input logic [RATE_W-1:0] r
    );
        return (r > RATE_W'(RATE_MAX)) ? RATE_W'(RATE_MAX) : r;
    endfunction

endpackage

// File: rtl/lfsr_rand.sv
// 32-bit Galois LFSR with a 0..99 output for percentage draws.
// Deterministic from SEED so traces repeat across tools and silicon.
module lfsr_rand
    import srs_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [RATE_W-1:0] rnd
);

    logic [31:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
        end
    end

    assign rnd = RATE_W'(lfsr[15:0] % 16'd100);

endmodule

// File: rtl/stream_rate_scheduler.sv
// Phase-table driven generator for one stream vld/rdy line.
// Counts its own handshakes per phase and steps, loops or finishes.
module stream_rate_scheduler
    import srs_pkg::*;
#(
    parameter int          NUM_PHASES      = 4,
    parameter int          COUNT_W         = 16,
    parameter logic [31:0] LFSR_SEED       = 32'hACE1_2468,
    parameter bit          HOLD_UNTIL_XFER = 1'b1,
    localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [PW-1:0]      cfg_idx,
    input  logic [RATE_W-1:0]  cfg_rate,
    input  logic [COUNT_W-1:0] cfg_count,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    input  logic               ctl_in,
    output logic               ctl_out,
    output logic               busy,
    output logic [PW-1:0]      phase,
    output logic [COUNT_W-1:0] xfer_cnt,
    output logic               done
);

    localparam logic [PW-1:0] LAST = PW'(NUM_PHASES - 1);

    state_t             state;
    logic [RATE_W-1:0]  rate_tbl [NUM_PHASES];
    logic [COUNT_W-1:0] cnt_tbl  [NUM_PHASES];
    logic [RATE_W-1:0]  rnd;
    logic               xfer;
    logic               last_xfer;
    logic               want;
    logic               is_last;
    logic [PW-1:0]      nxt;

    lfsr_rand #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == RUN),
        .rnd   (rnd)
    );

    assign busy      = (state != IDLE);
    assign xfer      = ctl_out & ctl_in;
    assign last_xfer = xfer &&
                       ((xfer_cnt + COUNT_W'(1)) == cnt_tbl[phase]);
    assign want      = (rnd < rate_tbl[phase]) |
                       (HOLD_UNTIL_XFER & ctl_out & ~ctl_in);
    assign is_last   = (phase == LAST);
    assign nxt       = is_last ? '0 : phase + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                rate_tbl[i] <= '0;
                cnt_tbl[i]  <= '0;
            end
        end else if (cfg_we && state == IDLE &&
                     int'(cfg_idx) < NUM_PHASES) begin
            rate_tbl[cfg_idx] <= clamp_rate(cfg_rate);
            cnt_tbl[cfg_idx]  <= cfg_count;
        end
    end

    // stop has priority everywhere; a coincident transfer is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ctl_out  <= 1'b0;
            phase    <= '0;
            xfer_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !stop) begin
                        phase    <= '0;
                        xfer_cnt <= '0;
                        ctl_out  <= 1'b0;
                        state    <= (cnt_tbl[0] == '0) ? ADVANCE : RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state    <= IDLE;
                        ctl_out  <= 1'b0;
                        phase    <= '0;
                        xfer_cnt <= '0;
                    end else if (last_xfer) begin
                        ctl_out  <= 1'b0;
                        xfer_cnt <= '0;
                        state    <= ADVANCE;
                    end else begin
                        if (xfer) xfer_cnt <= xfer_cnt + COUNT_W'(1);
                        ctl_out <= want;
                    end
                end
                ADVANCE: begin
                    ctl_out  <= 1'b0;
                    xfer_cnt <= '0;
                    if (stop) begin
                        state <= IDLE;
                        phase <= '0;
                    end else if (is_last && !loop_en) begin
                        done  <= 1'b1;
                        phase <= '0;
                        state <= IDLE;
                    end else begin
                        phase <= nxt;
                        state <= (cnt_tbl[nxt] == '0) ? ADVANCE : RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_rate_scheduler.sv
// Self-checking bench for stream_rate_scheduler: vector table,
// handshake scoreboard and hand-written multi-cycle sequences.
module tb_stream_rate_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [6:0]  cfg_rate = '0;
    logic [15:0] cfg_count = '0;
    logic        loop_en = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        ctl_in = 1'b0;
    logic        ctl_out;
    logic        busy;
    logic [1:0]  phase;
    logic [15:0] xfer_cnt;
    logic        done;

    stream_rate_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_rate  (cfg_rate),
        .cfg_count (cfg_count),
        .loop_en   (loop_en),
        .start     (start),
        .stop      (stop),
        .ctl_in    (ctl_in),
        .ctl_out   (ctl_out),
        .busy      (busy),
        .phase     (phase),
        .xfer_cnt  (xfer_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:3][6:0]  r;
        logic [0:3][15:0] c;
        int               hi;
        int               cyc;
    } vec_t;

    vec_t vecs [5];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   ci_pat [600];
    int   sb [$];
    int   trc [$];
    int   tr0 [$];
    bit   sb_on = 1'b0;
    int   m_tbl [4] = '{5, 2, 0, 0};
    int   m_cnt, m_ph, hold_viol;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input int r, input int c);
        cfg_we    = 1'b1;
        cfg_idx   = 2'(idx);
        cfg_rate  = 7'(r);
        cfg_count = 16'(c);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic run(input int budget, input bit use_pat,
                       output int hi, output int cyc, output bit gd);
        bit po, pi;
        hi = 0;
        cyc = 0;
        gd = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (!gd && cyc < budget) begin
            if (use_pat) ctl_in = ci_pat[cyc];
            if (sb_on && ctl_out && ctl_in) begin
                m_cnt++;
                if (m_ph < 4 && m_cnt == m_tbl[m_ph]) begin
                    sb.push_back(0);
                    m_cnt = 0;
                    m_ph++;
                end else begin
                    sb.push_back(m_cnt);
                end
            end
            po = ctl_out;
            pi = ctl_in;
            step();
            cyc++;
            if (sb_on && sb.size() > 0)
                chk("xfer_cnt", int'(xfer_cnt), sb.pop_front());
            if (po && !pi && !ctl_out) hold_viol++;
            hi += int'(ctl_out);
            trc.push_back(int'(ctl_out));
            gd = done;
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int hi, cyc, k, nd, diffs;
        bit gd;

        for (int i = 0; i < 600; i++) ci_pat[i] = 1'($urandom_range(0, 1));
        vecs[0] = '{r: {7'd100, 7'd0, 7'd0, 7'd0},
                    c: {16'd3, 16'd0, 16'd0, 16'd0}, hi: 3, cyc: 8};
        vecs[1] = '{r: {7'd0, 7'd0, 7'd0, 7'd0},
                    c: {16'd0, 16'd0, 16'd0, 16'd0}, hi: 0, cyc: 4};
        vecs[2] = '{r: {7'd127, 7'd100, 7'd0, 7'd120},
                    c: {16'd2, 16'd1, 16'd0, 16'd4}, hi: 7, cyc: 14};
        vecs[3] = '{r: {7'd100, 7'd100, 7'd100, 7'd100},
                    c: {16'd1, 16'd1, 16'd1, 16'd1}, hi: 4, cyc: 12};
        vecs[4] = '{r: {7'd0, 7'd0, 7'd0, 7'd100},
                    c: {16'd0, 16'd0, 16'd0, 16'd5}, hi: 5, cyc: 10};

        #2;
        chk("rst_ctl_out", int'(ctl_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_xfer_cnt", int'(xfer_cnt), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // rate-100 tables with partner always ready: exact timing
        ctl_in = 1'b1;
        foreach (vecs[v]) begin
            for (int i = 0; i < 4; i++)
                wr(i, int'(vecs[v].r[i]), int'(vecs[v].c[i]));
            run(100, 1'b0, hi, cyc, gd);
            chk($sformatf("v%0d_done", v), int'(gd), 1);
            chk($sformatf("v%0d_high", v), hi, vecs[v].hi);
            chk($sformatf("v%0d_cycles", v), cyc, vecs[v].cyc);
            chk($sformatf("v%0d_busy", v), int'(busy), 0);
            chk($sformatf("v%0d_phase", v), int'(phase), 0);
            step();
            chk($sformatf("v%0d_done_pulse", v), int'(done), 0);
        end

        // random partner, scoreboard on xfer_cnt, repeat for determinism
        for (int r = 0; r < 2; r++) begin
            reset_dut();
            wr(0, 50, 5);
            wr(1, 20, 2);
            sb.delete();
            trc.delete();
            m_cnt = 0;
            m_ph = 0;
            hold_viol = 0;
            sb_on = 1'b1;
            run(600, 1'b1, hi, cyc, gd);
            sb_on = 1'b0;
            chk("rand_done", int'(gd), 1);
            chk("rand_hold", hold_viol, 0);
            chk("rand_phases_done", m_ph, 2);
            chk("rand_sb_empty", sb.size(), 0);
            if (r == 0) begin
                tr0 = trc;
            end else begin
                diffs = 0;
                foreach (trc[i])
                    if (i < tr0.size() && trc[i] != tr0[i]) diffs++;
                chk("trace_len", trc.size(), tr0.size());
                chk("trace_diff", diffs, 0);
            end
        end

        // duty cycle at rate 30
        ctl_in = 1'b1;
        wr(0, 30, 1000);
        wr(1, 0, 0);
        run(5000, 1'b0, hi, cyc, gd);
        chk("duty_done", int'(gd), 1);
        chk("duty_high", hi, 1000);
        chk("duty_30pct",
            int'((hi * 100 >= 27 * cyc) && (hi * 100 <= 33 * cyc)), 1);

        // looping two phases, then abort mid-phase
        wr(0, 100, 2);
        wr(1, 100, 2);
        loop_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            nd += int'(done);
            if (ctl_out) begin
                chk("loop_phase", int'(phase), (k / 2) % 2);
                k++;
            end
        end
        chk("loop_no_done", nd, 0);
        chk("loop_enough_xfers", int'(k >= 12), 1);
        for (int i = 0; i < 20 && xfer_cnt != 16'd1; i++) step();
        chk("stop_setup", int'(xfer_cnt), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_ctl_out", int'(ctl_out), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_phase", int'(phase), 0);
        chk("stop_xfer_cnt", int'(xfer_cnt), 0);
        chk("stop_done", int'(done), 0);
        step();
        chk("stop_done_later", int'(done), 0);
        chk("stop_busy_later", int'(busy), 0);
        loop_en = 1'b0;

        // start and stop together while idle
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_busy", int'(busy), 0);
        step();
        chk("startstop_busy2", int'(busy), 0);

        // table writes while busy must be ignored
        wr(0, 100, 3);
        wr(1, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_we = 1'b1;
        cfg_idx = 2'd0;
        cfg_rate = 7'd0;
        cfg_count = 16'd1;
        step();
        cfg_idx = 2'd1;
        cfg_rate = 7'd100;
        cfg_count = 16'd5;
        step();
        cfg_we = 1'b0;
        gd = 1'b0;
        for (int i = 0; i < 50 && !gd; i++) begin
            step();
            gd = done;
        end
        chk("busywr_first_done", int'(gd), 1);
        run(100, 1'b0, hi, cyc, gd);
        chk("busywr_high", hi, 3);
        chk("busywr_cycles", cyc, 8);

        // async reset in the middle of a run
        wr(0, 100, 1000);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("prerst_ctl_out", int'(ctl_out), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_ctl_out", int'(ctl_out), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_phase", int'(phase), 0);
        chk("arst_xfer_cnt", int'(xfer_cnt), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        run(20, 1'b0, hi, cyc, gd);
        chk("arst_tbl_done", int'(gd), 1);
        chk("arst_tbl_high", hi, 0);
        chk("arst_tbl_cycles", cyc, 4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_rate_scheduler.md
Name: stream_rate_scheduler

Overview:
- Synthesizable sequencer for one stream control line (vld or rdy): steps through a programmed table of phases, each with its own rate and its own transaction budget.
- Randomness comes from an internal LFSR, not $urandom, so runs repeat exactly across simulators and on FPGA.
- Sits between bench or BIST config logic and a stream interface; counts handshakes itself and stops, loops or reports completion.

Parameters:
- NUM_PHASES, 4, entries in phase table (>=1).
- COUNT_W, 16, width of per-phase transaction budget and transfer counter.
- LFSR_SEED, 32'hACE1_2468, LFSR reset value; must be nonzero.
- HOLD_UNTIL_XFER, 1, 1 = once ctl_out rises it holds until handshake; 0 = fully random each cycle.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- cfg_we  in  1  write phase table entry.
- cfg_idx  in  $clog2(NUM_PHASES) (min 1)  entry index.
- cfg_rate  in  7  percent, 0..100; values >100 treated as 100.
- cfg_count  in  COUNT_W  transfers in phase; 0 = skip phase.
- loop_en  in  1  after last phase restart at phase 0.
- start  in  1  pulse, begin at phase 0.
- stop  in  1  pulse, abort.
- ctl_in  in  1  partner handshake signal.
- ctl_out  out  1  generated control (registered).
- busy  out  1  high in RUN/ADVANCE.
- phase  out  $clog2(NUM_PHASES)  current phase index.
- xfer_cnt  out  COUNT_W  transfers completed in current phase.
- done  out  1  one-cycle pulse at sequence end.

Behaviour:
- Reset (async assert): state IDLE, ctl_out=0, busy=0, phase=0, xfer_cnt=0, done=0, lfsr=LFSR_SEED, all table entries rate=0/count=0. Deassertion is synchronized by the user.
- Table writes accepted only in IDLE; cfg_we while busy is ignored (no effect, no error).
- States: IDLE, RUN, ADVANCE.
- IDLE: start (and not stop) at edge N -> RUN at N with phase=0, xfer_cnt=0. If entry 0 count=0, go to ADVANCE instead. start and stop in the same cycle: stop wins, stay IDLE.
- LFSR: 32-bit Galois, taps 32,22,2,1. Advances every cycle in RUN only. r = lfsr[15:0] mod 100.
- RUN, each edge: xfer = ctl_out & ctl_in.
  - If xfer: xfer_cnt+1.
  - If xfer and xfer_cnt+1 == count[phase]: ctl_out<=0, xfer_cnt<=0, state ADVANCE.
  - Otherwise: ctl_out <= (r < rate[phase]) | (HOLD_UNTIL_XFER & ctl_out & ~ctl_in).
  - First possible ctl_out=1 is after edge N+1.
- ADVANCE (1 cycle per step, ctl_out=0):
  - If phase < NUM_PHASES-1: phase+1.
  - Else if loop_en: phase=0.
  - Else: done=1 for one cycle, phase=0, state IDLE.
  - Next phase with count=0: stay in ADVANCE (skip, one cycle each).
  - Next phase with count>0: go to RUN.
  - All counts 0 with loop_en: cycles in ADVANCE until stop. This is legal and documented.
- rate 0 with count>0: phase never completes; only stop exits.
- rate 100: ctl_out=1 every RUN cycle except the cycle after the phase-ending transfer.
- stop in RUN or ADVANCE: at that edge ctl_out<=0, state IDLE, phase=0, xfer_cnt=0, no done. A transfer in the same cycle is discarded.
- start while busy: ignored.
- xfer_cnt never wraps, because it is cleared when it reaches count.
- busy = (state != IDLE), combinational from state register.

Decomposition:
- Shared package srs_pkg: state enum (IDLE, RUN, ADVANCE), RATE_MAX=100, RATE_W=7, LFSR_TAPS=32'h80200003.
- Sub-module lfsr_rand: LFSR register, enable, seed parameter, 7-bit mod-100 output. Reused later by other random generators.

Test Plan:
- Phase0 rate=100 count=3, ctl_in tied 1, loop_en=0, start -> ctl_out high 3 cycles, low 1 (ADVANCE), phases 1..3 count 0 skipped one cycle each, then done pulse, busy=0.
- Phases {rate 50,count 5},{rate 20,count 2}, ctl_in random, HOLD_UNTIL_XFER=1 -> ctl_out never falls without ctl_in=1. xfer_cnt reaches 5 then 2. Two runs with the same seed give identical ctl_out traces.
- rate=30 count=1000, ctl_in=1 -> measured duty 30% ±3%.
- loop_en=1, two phases count 2 each -> phase sequence 0,1,0,1..., no done. stop mid-phase -> next cycle ctl_out=0, busy=0, phase=0, no done.
- start and stop same cycle in IDLE -> remains IDLE. cfg_we while busy changes nothing (read back via a following run).
- rst_n asserted mid-RUN with ctl_out=1 -> ctl_out=0 immediately (async). After release the table is cleared: a start with default table goes through 4 ADVANCE cycles, then done.
